pe_cluster: RTL and testbench
=============================

// Module: pe_cluster
// PURPOSE
//   Cluster of 16 int8 MAC processing elements (PEs). All PEs share one 4-lane IFM word; each PE has a private 4-lane weight word.
//   Each PE accumulates 4-lane dot products while enabled. On finish it emits one requantized int8 OFM byte with a 1-cycle valid pulse.
//   Sits between the weight/IFM buffers and the OFM write-back path of the conv datapath.
// PARAMETERS
//   ACC_W      32  accumulator width, signed two's complement; wraps on overflow
//   OUT_SHIFT  0   arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)
// PORTS
//   clk                    in   1   clock, rising edge
//   reset_n                in   1   asynchronous, active-low reset
//   Weight_0..Weight_15    in   32  per-PE weights; lane k = bits[8k+7:8k], signed int8, k=0..3
//   IFM                    in   32  shared input feature map; same lane packing, signed int8
//   PE_en                  in   16  bit i: accumulate this cycle's dot product into PE i
//   PE_finish              in   16  bit i: close PE i's accumulation and emit its result
//   OFM_0..OFM_15          out  8   per-PE result, signed int8, registered
//   valid                  out  16  bit i high for exactly 1 cycle when OFM_i is updated
// BEHAVIOUR
//   - Reset is asynchronous and active-low. While reset_n=0: all accumulators = 0, all OFM_i = 8'h00, valid = 16'h0000.
//   - Reset dominates all other inputs, including X on PE_en / PE_finish. Reset asserted mid-accumulation discards partial sums.
//   - Per PE i, each cycle:
//       dot  = sum over k=0..3 of sext(IFM lane k) * sext(Weight_i lane k)
//              (19-bit signed, sign-extended to ACC_W)
//       nxt  = acc_i + (PE_en[i] ? dot : 0)
//   - Rising edge, PE_finish[i]=0:
//       acc_i <= nxt; valid[i] <= 0; OFM_i holds its value.
//   - Rising edge, PE_finish[i]=1:
//       OFM_i <= sat8(nxt >>> OUT_SHIFT); valid[i] <= 1; acc_i <= 0.
//       If PE_en[i]=1 in the same cycle, the current dot IS included in the result.
//   - sat8: clamp to [-128, +127].
//   - Latency: OFM_i / valid[i] appear on the edge that samples PE_finish[i], i.e. 1 clock after finish is presented.
//   - Back-to-back PE_finish: each cycle emits a fresh result. A finish with no prior enables emits 0 (or the current dot if en=1).
//   - The 16 PEs are fully independent. Any mix of en/finish bits is legal in any cycle.
//   - Accumulator overflow wraps modulo 2^ACC_W and is not flagged.
//   - No stall or backpressure: the consumer must take OFM_i in the cycle valid[i]=1.
// CONFIGURATION
//   PE_CLUSTER_RELU_EN defined:
//     ReLU is applied after shift and before saturation; negative results emit 8'h00.
//     Output range becomes 0..127.
//   PE_CLUSTER_RELU_EN undefined:
//     Signed output, range -128..127.
// TESTING
//   1. Reset: reset_n=0 with PE_en=16'hFFFF and PE_finish=X
//      -> all OFM=00, valid=0000; after release with en=0, outputs stay 00 / 0000.
//   2. Basic: IFM=32'h01020304, Weight_i=i, OUT_SHIFT=0, PE_en=FFFF 1 cycle, then PE_finish=FFFF 1 cycle
//      -> OFM_i = 4*i (00,04,...,3C); valid=FFFF for exactly 1 cycle, then 0000.
//   3. Accumulate + same-cycle finish: setup as test 2; en=FFFF for 3 cycles, with finish=FFFF in the 3rd
//      -> OFM_i = 12*i, saturated (i>=11 -> 7F).
//   4. Saturation: IFM=Weight_0=32'h7F7F7F7F, en 1 cycle, finish -> dot=64516 -> OFM_0=7F.
//      IFM=32'h80808080, Weight_0=32'h7F7F7F7F -> OFM_0=80.
//   5. Negative / ReLU: IFM=32'h01010101, Weight_0=32'hFFFFFFFF, en 1 cycle, finish
//      -> OFM_0=FC without macro, 00 with PE_CLUSTER_RELU_EN.
//   6. Independence + reset mid-op: PE_en=0x0005 for 2 cycles, then finish=0x0007
//      -> only PEs 0,2 hold accumulated values; PE1 emits 00; valid=0007.
//      reset_n pulsed between en and finish -> all emit 00.

Source files
------------

// File: rtl/pe_cluster.sv
// Cluster of 16 int8 MAC processing elements sharing one 4-lane IFM word.
// Optional macro PE_CLUSTER_RELU_EN clamps negative results to zero before saturation.
module pe_cluster #(
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Weight_0,
    input  logic [31:0] Weight_1,
    input  logic [31:0] Weight_2,
    input  logic [31:0] Weight_3,
    input  logic [31:0] Weight_4,
    input  logic [31:0] Weight_5,
    input  logic [31:0] Weight_6,
    input  logic [31:0] Weight_7,
    input  logic [31:0] Weight_8,
    input  logic [31:0] Weight_9,
    input  logic [31:0] Weight_10,
    input  logic [31:0] Weight_11,
    input  logic [31:0] Weight_12,
    input  logic [31:0] Weight_13,
    input  logic [31:0] Weight_14,
    input  logic [31:0] Weight_15,
    input  logic [31:0] IFM,
    input  logic [15:0] PE_en,
    input  logic [15:0] PE_finish,
    output logic [7:0]  OFM_0,
    output logic [7:0]  OFM_1,
    output logic [7:0]  OFM_2,
    output logic [7:0]  OFM_3,
    output logic [7:0]  OFM_4,
    output logic [7:0]  OFM_5,
    output logic [7:0]  OFM_6,
    output logic [7:0]  OFM_7,
    output logic [7:0]  OFM_8,
    output logic [7:0]  OFM_9,
    output logic [7:0]  OFM_10,
    output logic [7:0]  OFM_11,
    output logic [7:0]  OFM_12,
    output logic [7:0]  OFM_13,
    output logic [7:0]  OFM_14,
    output logic [7:0]  OFM_15,
    output logic [15:0] valid
);

    localparam int NUM_PE = 16;
    localparam int LANES  = 4;
    localparam int DOT_W  = 19;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

    logic [31:0] weight_w [NUM_PE];
    logic [7:0]  ofm_w    [NUM_PE];

    assign weight_w[0]  = Weight_0;
    assign weight_w[1]  = Weight_1;
    assign weight_w[2]  = Weight_2;
    assign weight_w[3]  = Weight_3;
    assign weight_w[4]  = Weight_4;
    assign weight_w[5]  = Weight_5;
    assign weight_w[6]  = Weight_6;
    assign weight_w[7]  = Weight_7;
    assign weight_w[8]  = Weight_8;
    assign weight_w[9]  = Weight_9;
    assign weight_w[10] = Weight_10;
    assign weight_w[11] = Weight_11;
    assign weight_w[12] = Weight_12;
    assign weight_w[13] = Weight_13;
    assign weight_w[14] = Weight_14;
    assign weight_w[15] = Weight_15;

    assign OFM_0  = ofm_w[0];
    assign OFM_1  = ofm_w[1];
    assign OFM_2  = ofm_w[2];
    assign OFM_3  = ofm_w[3];
    assign OFM_4  = ofm_w[4];
    assign OFM_5  = ofm_w[5];
    assign OFM_6  = ofm_w[6];
    assign OFM_7  = ofm_w[7];
    assign OFM_8  = ofm_w[8];
    assign OFM_9  = ofm_w[9];
    assign OFM_10 = ofm_w[10];
    assign OFM_11 = ofm_w[11];
    assign OFM_12 = ofm_w[12];
    assign OFM_13 = ofm_w[13];
    assign OFM_14 = ofm_w[14];
    assign OFM_15 = ofm_w[15];

    // Shift, optional ReLU, then clamp to the int8 range.
    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        logic [7:0]              res;
        sh = acc >>> OUT_SHIFT;
        if (sh > SAT_MAX) begin
            res = 8'h7F;
        end else if (sh < SAT_MIN) begin
            res = 8'h80;
        end else begin
            res = sh[7:0];
        end
`ifdef PE_CLUSTER_RELU_EN
        if (sh < 0) begin
            res = 8'h00;
        end
`endif
        return res;
    endfunction

    for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
        logic signed [DOT_W-1:0] dot;
        logic signed [ACC_W-1:0] nxt;
        logic signed [ACC_W-1:0] acc_q, acc_d;
        logic [7:0]              ofm_q, ofm_d;
        logic                    valid_q, valid_d;

        always_comb begin
            logic signed [7:0]  a;
            logic signed [7:0]  b;
            logic signed [15:0] prod;
            dot = '0;
            for (int k = 0; k < LANES; k++) begin
                a    = IFM[8*k +: 8];
                b    = weight_w[g][8*k +: 8];
                prod = a * b;
                dot  = dot + DOT_W'(prod);
            end
        end

        assign nxt = acc_q + (PE_en[g] ? ACC_W'(dot) : '0);

        always_comb begin
            acc_d   = nxt;
            ofm_d   = ofm_q;
            valid_d = 1'b0;
            if (PE_finish[g]) begin
                acc_d   = '0;
                ofm_d   = requant(nxt);
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_q   <= '0;
                ofm_q   <= 8'h00;
                valid_q <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                ofm_q   <= ofm_d;
                valid_q <= valid_d;
            end
        end

        assign ofm_w[g] = ofm_q;
        assign valid[g] = valid_q;
    end

endmodule

// File: tb/tb_pe_cluster.sv
// Directed self-checking bench for pe_cluster: reset, accumulation, saturation, sign, independence.
module tb_pe_cluster;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] w [16];
    logic [31:0] ifm = '0;
    logic [15:0] en = '0;
    logic [15:0] fin = '0;
    logic [7:0]  ofm [16];
    logic [15:0] valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_cluster dut (
        .clk(clk), .reset_n(reset_n),
        .Weight_0(w[0]),   .Weight_1(w[1]),   .Weight_2(w[2]),   .Weight_3(w[3]),
        .Weight_4(w[4]),   .Weight_5(w[5]),   .Weight_6(w[6]),   .Weight_7(w[7]),
        .Weight_8(w[8]),   .Weight_9(w[9]),   .Weight_10(w[10]), .Weight_11(w[11]),
        .Weight_12(w[12]), .Weight_13(w[13]), .Weight_14(w[14]), .Weight_15(w[15]),
        .IFM(ifm), .PE_en(en), .PE_finish(fin),
        .OFM_0(ofm[0]),   .OFM_1(ofm[1]),   .OFM_2(ofm[2]),   .OFM_3(ofm[3]),
        .OFM_4(ofm[4]),   .OFM_5(ofm[5]),   .OFM_6(ofm[6]),   .OFM_7(ofm[7]),
        .OFM_8(ofm[8]),   .OFM_9(ofm[9]),   .OFM_10(ofm[10]), .OFM_11(ofm[11]),
        .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
        .valid(valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        for (int i = 0; i < 16; i++) w[i] = '0;

        // 1. reset dominates enables and unknown finish
        en  = 16'hFFFF;
        fin = 'x;
        ifm = 32'h01020304;
        tick();
        tick();
        for (int i = 0; i < 16; i++) chk($sformatf("rst_ofm%0d", i), 16'(ofm[i]), 16'h0000);
        chk("rst_valid", valid, 16'h0000);
        en  = 16'h0000;
        fin = 16'h0000;
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", valid, 16'h0000);
        chk("post_rst_ofm5", 16'(ofm[5]), 16'h0000);

        // 2. single-cycle dot: OFM_i = 4*i
        for (int i = 0; i < 16; i++) w[i] = 32'(i);
        ifm = 32'h01020304;
        en  = 16'hFFFF;
        tick();
        en  = 16'h0000;
        fin = 16'hFFFF;
        tick();
        chk("basic_valid", valid, 16'hFFFF);
        for (int i = 0; i < 16; i++) chk($sformatf("basic_ofm%0d", i), 16'(ofm[i]), 16'(4 * i));
        fin = 16'h0000;
        tick();
        chk("basic_valid_drop", valid, 16'h0000);
        chk("basic_hold15", 16'(ofm[15]), 16'h003C);

        // 3. three enabled cycles, finish on the third
        en = 16'hFFFF;
        tick();
        tick();
        fin = 16'hFFFF;
        tick();
        en  = 16'h0000;
        fin = 16'h0000;
        chk("acc3_valid", valid, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            e = (12 * i > 127) ? 8'h7F : 8'(12 * i);
            chk($sformatf("acc3_ofm%0d", i), 16'(ofm[i]), 16'(e));
        end
        tick();
        chk("acc3_valid_drop", valid, 16'h0000);

        // 4. positive and negative saturation on PE0
        w[0] = 32'h7F7F7F7F;
        ifm  = 32'h7F7F7F7F;
        en   = 16'h0001;
        tick();
        en  = 16'h0000;
        fin = 16'h0001;
        tick();
        fin = 16'h0000;
        chk("satpos_valid", valid, 16'h0001);
        chk("satpos_ofm0", 16'(ofm[0]), 16'h007F);
        ifm = 32'h80808080;
        en  = 16'h0001;
        tick();
        en  = 16'h0000;
        fin = 16'h0001;
        tick();
        fin = 16'h0000;
        chk("satneg_ofm0", 16'(ofm[0]), 16'h0080);

        // 5. small negative result (dot = -4)
        ifm  = 32'h01010101;
        w[0] = 32'hFFFFFFFF;
        en   = 16'h0001;
        tick();
        en  = 16'h0000;
        fin = 16'h0001;
        tick();
        fin = 16'h0000;
`ifdef PE_CLUSTER_RELU_EN
        chk("neg_ofm0", 16'(ofm[0]), 16'h0000);
`else
        chk("neg_ofm0", 16'(ofm[0]), 16'h00FC);
`endif

        // 6. independence: PE0 dot=12, PE2 dot=8, two cycles; PE1 finishes empty
        ifm  = 32'h01020304;
        w[0] = 32'h00000003;
        en   = 16'h0005;
        tick();
        tick();
        en  = 16'h0000;
        fin = 16'h0007;
        tick();
        chk("indep_valid", valid, 16'h0007);
        chk("indep_ofm0", 16'(ofm[0]), 16'h0018);
        chk("indep_ofm1", 16'(ofm[1]), 16'h0000);
        chk("indep_ofm2", 16'(ofm[2]), 16'h0010);
        chk("indep_ofm3_hold", 16'(ofm[3]), 16'h0024);
        // back-to-back finish: PE2 enabled this cycle only, PE0 empty
        en = 16'h0004;
        tick();
        en  = 16'h0000;
        fin = 16'h0000;
        chk("b2b_valid", valid, 16'h0007);
        chk("b2b_ofm0", 16'(ofm[0]), 16'h0000);
        chk("b2b_ofm2", 16'(ofm[2]), 16'h0008);

        // reset pulse between accumulation and finish discards partial sums
        en = 16'h0005;
        tick();
        tick();
        en = 16'h0000;
        reset_n = 1'b0;
        #2;
        chk("midrst_async_ofm2", 16'(ofm[2]), 16'h0000);
        reset_n = 1'b1;
        fin = 16'h0007;
        tick();
        fin = 16'h0000;
        chk("midrst_valid", valid, 16'h0007);
        chk("midrst_ofm0", 16'(ofm[0]), 16'h0000);
        chk("midrst_ofm2", 16'(ofm[2]), 16'h0000);
        tick();
        chk("final_valid", valid, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
